// File: rtl/sd_cmd_ctrl_pkg.sv
// Shared definitions for the SD SPI-mode command framer: FSM encoding,
// command indices, R1 bit masks, CRC7 constants, the response register
// bank layout and the CRC helpers.
package sd_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_ISSUE = 3'd1,
        ST_TX_WAIT  = 3'd2,
        ST_RX_ISSUE = 3'd3,
        ST_RX_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [5:0] SD_CMD0   = 6'd0;
    localparam logic [5:0] SD_CMD8   = 6'd8;
    localparam logic [5:0] SD_CMD55  = 6'd55;
    localparam logic [5:0] SD_ACMD41 = 6'd41;
    localparam logic [5:0] SD_CMD58  = 6'd58;

    localparam logic [7:0] R1_IDLE        = 8'h01;
    localparam logic [7:0] R1_ERASE_RESET = 8'h02;
    localparam logic [7:0] R1_ILLEGAL_CMD = 8'h04;
    localparam logic [7:0] R1_CRC_ERR     = 8'h08;
    localparam logic [7:0] R1_ERASE_SEQ   = 8'h10;
    localparam logic [7:0] R1_ADDR_ERR    = 8'h20;
    localparam logic [7:0] R1_PARAM_ERR   = 8'h40;
    localparam logic [7:0] R1_START_MASK  = 8'h80;

    // x^7 + x^3 + 1, x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Response fields and status live together so they update atomically
    typedef struct packed {
        logic        valid;
        logic [7:0]  r1;
        logic [31:0] data;
        logic        timeout;
    } resp_bank_t;

    // Pre-computed CRC bytes for the only two commands that need a valid CRC in SPI mode
    function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            SD_CMD0: b = 8'h95;
            SD_CMD8: b = 8'h87;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // Serial CRC7 over 40 message bits, MSB first, initial value 0
    function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ CRC7_POLY;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_cmd_ctrl_crc7.sv
// Combinational CRC7 of the 40-bit SD command header {2'b01, index, arg}.
module sd_cmd_ctrl_crc7
    import sd_cmd_ctrl_pkg::*;
(
    input  logic [39:0] frame_bits,
    output logic [6:0]  crc
);

    // Whole CRC evaluated in one cycle so it is ready at command accept
    always_comb begin
        crc = crc7_calc(frame_bits);
    end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD-card SPI-mode command framer and response collector.
// Sends DUMMY_BYTES x 0xFF then the 6-byte command frame through the byte
// engine's write handshake, then polls for R1 (and 4 data bytes for R3/R7).
// Build option: define SD_CRC7_EN for a computed CRC7; otherwise the CRC byte
// is fixed (0x95 for CMD0, 0x87 for CMD8, 0xFF otherwise).
// DUMMY_BYTES + 5 must fit the 3-bit byte counter (DUMMY_BYTES <= 2).
module sd_cmd_ctrl
    import sd_cmd_ctrl_pkg::*;
#(
    parameter int DUMMY_BYTES = 1,
    parameter int NCR_MAX     = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_long,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        busy,
    output logic [7:0]  spi_data_write,
    output logic        spi_write_en,
    input  logic        spi_write_busy,
    output logic        spi_read_en,
    input  logic        spi_read_busy,
    input  logic [7:0]  spi_data_read
);

    localparam logic [2:0] DUMMY_CNT = 3'(DUMMY_BYTES);
    localparam logic [2:0] TX_LAST   = 3'(DUMMY_BYTES + 5);
    localparam logic [7:0] POLL_LAST = 8'(NCR_MAX - 1);
    localparam logic [7:0] POLL_LIM  = 8'(NCR_MAX);

    state_t      state_r, state_nxt;
    logic        skip_r, skip_nxt;
    logic [2:0]  byte_cnt_r, byte_cnt_nxt;
    logic [7:0]  poll_cnt_r, poll_cnt_nxt;
    logic        data_phase_r, data_phase_nxt;
    logic [47:0] frame_r;
    logic        long_r;
    resp_bank_t  resp_r, resp_nxt;
    logic        cmd_ready_r, busy_r;
    logic        wr_en_r, wr_en_nxt;
    logic        rd_en_r, rd_en_nxt;
    logic [7:0]  wr_data_r, wr_data_nxt;
    logic        accept_s;
    logic [7:0]  crc_byte_s;
    logic [7:0]  tx_byte_s;
    logic [2:0]  frame_idx_s;

`ifdef SD_CRC7_EN
    logic [6:0] crc7_s;

    sd_cmd_ctrl_crc7 u_crc7 (
        .frame_bits ({2'b01, cmd_index, cmd_arg}),
        .crc        (crc7_s)
    );

    assign crc_byte_s = {crc7_s, 1'b1};
`else
    assign crc_byte_s = fixed_crc_byte(cmd_index);
`endif

    assign accept_s = (state_r == ST_IDLE) && cmd_valid;

    // Select the wire byte for the current byte count: sync fill, then frame MSB-first
    always_comb begin
        frame_idx_s = byte_cnt_r - DUMMY_CNT;
        tx_byte_s   = 8'hFF;
        if (byte_cnt_r < DUMMY_CNT) begin
            tx_byte_s = 8'hFF;
        end else begin
            case (frame_idx_s)
                3'd0:    tx_byte_s = frame_r[47:40];
                3'd1:    tx_byte_s = frame_r[39:32];
                3'd2:    tx_byte_s = frame_r[31:24];
                3'd3:    tx_byte_s = frame_r[23:16];
                3'd4:    tx_byte_s = frame_r[15:8];
                3'd5:    tx_byte_s = frame_r[7:0];
                default: tx_byte_s = 8'hFF;
            endcase
        end
    end

    // Next-state and next-output logic for the framing/polling sequence
    always_comb begin
        state_nxt      = state_r;
        skip_nxt       = 1'b0;
        byte_cnt_nxt   = byte_cnt_r;
        poll_cnt_nxt   = poll_cnt_r;
        data_phase_nxt = data_phase_r;
        wr_en_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        wr_data_nxt    = wr_data_r;
        resp_nxt       = resp_r;
        resp_nxt.valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt        = ST_TX_ISSUE;
                    byte_cnt_nxt     = 3'd0;
                    poll_cnt_nxt     = 8'd0;
                    data_phase_nxt   = 1'b0;
                    resp_nxt.r1      = 8'h00;
                    resp_nxt.data    = 32'h0000_0000;
                    resp_nxt.timeout = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TX_ISSUE: begin
                if (!spi_write_busy) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = tx_byte_s;
                    skip_nxt    = 1'b1;
                    state_nxt   = ST_TX_WAIT;
                end else begin
                    state_nxt = ST_TX_ISSUE;
                end
            end
            ST_TX_WAIT: begin
                // The first wait cycle is skipped so the engine can raise busy
                if (skip_r) begin
                    state_nxt = ST_TX_WAIT;
                end else if (!spi_write_busy) begin
                    if (byte_cnt_r == TX_LAST) begin
                        byte_cnt_nxt = 3'd0;
                        state_nxt    = ST_RX_ISSUE;
                    end else begin
                        byte_cnt_nxt = byte_cnt_r + 3'd1;
                        state_nxt    = ST_TX_ISSUE;
                    end
                end else begin
                    state_nxt = ST_TX_WAIT;
                end
            end
            ST_RX_ISSUE: begin
                if (!spi_read_busy) begin
                    rd_en_nxt = 1'b1;
                    skip_nxt  = 1'b1;
                    state_nxt = ST_RX_WAIT;
                end else begin
                    state_nxt = ST_RX_ISSUE;
                end
            end
            ST_RX_WAIT: begin
                if (skip_r) begin
                    state_nxt = ST_RX_WAIT;
                end else if (!spi_read_busy) begin
                    if (data_phase_r) begin
                        resp_nxt.data = {resp_r.data[23:0], spi_data_read};
                        if (byte_cnt_r == 3'd3) begin
                            resp_nxt.valid = 1'b1;
                            state_nxt      = ST_DONE;
                        end else begin
                            byte_cnt_nxt = byte_cnt_r + 3'd1;
                            state_nxt    = ST_RX_ISSUE;
                        end
                    end else if ((spi_data_read & R1_START_MASK) == 8'h00) begin
                        resp_nxt.r1 = spi_data_read;
                        if (long_r) begin
                            data_phase_nxt = 1'b1;
                            byte_cnt_nxt   = 3'd0;
                            state_nxt      = ST_RX_ISSUE;
                        end else begin
                            resp_nxt.valid = 1'b1;
                            state_nxt      = ST_DONE;
                        end
                    end else if (poll_cnt_r == POLL_LAST) begin
                        poll_cnt_nxt     = POLL_LIM;
                        resp_nxt.r1      = 8'hFF;
                        resp_nxt.timeout = 1'b1;
                        resp_nxt.valid   = 1'b1;
                        state_nxt        = ST_DONE;
                    end else begin
                        poll_cnt_nxt = poll_cnt_r + 8'd1;
                        state_nxt    = ST_RX_ISSUE;
                    end
                end else begin
                    state_nxt = ST_RX_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            skip_r       <= 1'b0;
            byte_cnt_r   <= 3'd0;
            poll_cnt_r   <= 8'd0;
            data_phase_r <= 1'b0;
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            wr_data_r    <= 8'hFF;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            skip_r       <= skip_nxt;
            byte_cnt_r   <= byte_cnt_nxt;
            poll_cnt_r   <= poll_cnt_nxt;
            data_phase_r <= data_phase_nxt;
            wr_en_r      <= wr_en_nxt;
            rd_en_r      <= rd_en_nxt;
            wr_data_r    <= wr_data_nxt;
            cmd_ready_r  <= (state_nxt == ST_IDLE);
            busy_r       <= (state_nxt != ST_IDLE);
        end
    end

    // Frame latch: header, argument, CRC and response length captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= 48'h0;
            long_r  <= 1'b0;
        end else if (accept_s) begin
            frame_r <= {2'b01, cmd_index, cmd_arg, crc_byte_s};
            long_r  <= resp_long;
        end else begin
            frame_r <= frame_r;
            long_r  <= long_r;
        end
    end

    // Response register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r <= '0;
        end else begin
            resp_r <= resp_nxt;
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign busy           = busy_r;
    assign spi_write_en   = wr_en_r;
    assign spi_read_en    = rd_en_r;
    assign spi_data_write = wr_data_r;
    assign resp_valid     = resp_r.valid;
    assign resp_r1        = resp_r.r1;
    assign resp_data      = resp_r.data;
    assign resp_timeout   = resp_r.timeout;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Self-checking bench for sd_cmd_ctrl: SPI byte-engine model, directed table,
// hand-written corner sequences and randomized commands against a reference model.
module tb_sd_cmd_ctrl;

    localparam int DUMMY = 1;
    localparam int NCR   = 8;
    localparam int FRAME = DUMMY + 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'h0;
    logic        resp_long = 1'b0;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        busy;
    logic [7:0]  spi_data_write;
    logic        spi_write_en;
    logic        spi_write_busy;
    logic        spi_read_en;
    logic        spi_read_busy;
    logic [7:0]  spi_data_read;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(.DUMMY_BYTES(DUMMY), .NCR_MAX(NCR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_long(resp_long),
        .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
        .resp_timeout(resp_timeout), .busy(busy),
        .spi_data_write(spi_data_write), .spi_write_en(spi_write_en),
        .spi_write_busy(spi_write_busy), .spi_read_en(spi_read_en),
        .spi_read_busy(spi_read_busy), .spi_data_read(spi_data_read)
    );

    int tests = 0;
    int fails = 0;

    // SPI byte-engine model state
    int          wr_len = 2;
    int          rd_len = 2;
    logic        hold_wr = 1'b0;
    logic        wbusy_m, rbusy_m;
    int          wleft, rleft;
    logic [7:0]  tx_log [0:4095];
    int          tx_cnt = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [7:0]  resp_mem [0:63];
    int          resp_len = 0;
    int          viol = 0;

    assign spi_write_busy = wbusy_m | hold_wr;
    assign spi_read_busy  = rbusy_m;

    // Engine: logs written bytes, serves responses from resp_mem, flags strobes while busy
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbusy_m <= 1'b0; wleft <= 0;
            rbusy_m <= 1'b0; rleft <= 0;
            spi_data_read <= 8'hFF;
        end else begin
            if (spi_write_en) begin
                if (spi_write_busy || spi_read_busy) viol <= viol + 1;
                tx_log[tx_cnt % 4096] <= spi_data_write;
                tx_cnt  <= tx_cnt + 1;
                wbusy_m <= 1'b1;
                wleft   <= wr_len - 1;
            end else if (wleft > 0) wleft <= wleft - 1;
            else wbusy_m <= 1'b0;
            if (spi_read_en) begin
                if (spi_write_busy || spi_read_busy) viol <= viol + 1;
                spi_data_read <= ((rd_cnt - rd_base) < resp_len) ? resp_mem[(rd_cnt - rd_base) % 64] : 8'hFF;
                rd_cnt  <= rd_cnt + 1;
                rbusy_m <= 1'b1;
                rleft   <= rd_len - 1;
            end else if (rleft > 0) rleft <= rleft - 1;
            else rbusy_m <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC byte: bit-serial CRC7 over {01,idx,arg} or the fixed table
    function automatic logic [7:0] crc_ref(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
        logic [39:0] m;
        logic [6:0]  c;
        m = {2'b01, idx, arg};
        c = 7'd0;
        for (int i = 39; i >= 0; i--)
            c = (c[6] ^ m[i]) ? ({c[5:0], 1'b0} ^ 7'h09) : {c[5:0], 1'b0};
        return {c, 1'b1};
`else
        return (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] exp_tx(input logic [5:0] idx, input logic [31:0] arg, input int k);
        logic [7:0] fr [0:5];
        fr[0] = {2'b01, idx};
        fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
        fr[5] = crc_ref(idx, arg);
        return (k < DUMMY) ? 8'hFF : fr[k - DUMMY];
    endfunction

    function automatic logic [7:0] rsp_at(input int i);
        return (i < resp_len) ? resp_mem[i] : 8'hFF;
    endfunction

    // Expected response: scan the card's byte stream for the first byte with bit7 clear
    task automatic model_resp(input logic lng, output logic [7:0] r1, output logic [31:0] data,
                              output logic to, output int nreads);
        logic [7:0] b;
        r1 = 8'hFF; data = 32'h0; to = 1'b1; nreads = NCR;
        for (int i = 0; i < NCR; i++) begin
            b = rsp_at(i);
            if (!b[7]) begin
                r1 = b; to = 1'b0; nreads = i + 1;
                if (lng) begin
                    for (int j = 0; j < 4; j++) data = {data[23:0], rsp_at(i + 1 + j)};
                    nreads += 4;
                end
                break;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic lng, input logic hold_valid, input int hold_cycles);
        int tb0, got;
        logic [7:0] er1; logic [31:0] edata; logic eto; int ereads;
        tb0 = tx_cnt;
        rd_base = rd_cnt;
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_long = lng; cmd_valid = 1'b1;
        hold_wr = (hold_cycles > 0);
        @(negedge clk);
        if (!hold_valid) begin
            cmd_valid = 1'b0;
            resp_long = ~lng;
            cmd_arg   = $urandom;
            cmd_index = 6'($urandom_range(0, 63));
        end
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == hold_cycles) hold_wr = 1'b0;
            if (hold_cycles > 0 && c == hold_cycles - 1)
                check({tag, " no_tx_while_busy"}, tx_cnt - tb0, 0);
            if (resp_valid) begin got = 1; break; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        hold_wr = 1'b0;
        check({tag, " resp_valid_seen"}, got, 1);
        model_resp(lng, er1, edata, eto, ereads);
        check({tag, " r1"}, resp_r1, er1);
        check({tag, " data"}, resp_data, edata);
        check({tag, " timeout"}, resp_timeout, eto);
        check({tag, " tx_count"}, tx_cnt - tb0, FRAME);
        for (int k = 0; k < FRAME; k++)
            check($sformatf("%s tx_byte%0d", tag, k), tx_log[(tb0 + k) % 4096], exp_tx(idx, arg, k));
        check({tag, " read_count"}, rd_cnt - rd_base, ereads);
        @(negedge clk);
        check({tag, " pulse_one_cycle"}, resp_valid, 0);
        check({tag, " ready_after"}, cmd_ready, 1);
    endtask

    typedef struct packed {
        logic [5:0]      idx;
        logic [31:0]     arg;
        logic            lng;
        int              nresp;
        logic [7:0][7:0] rsp;
        logic [7:0]      exp_crc;
        logic [7:0]      exp_r1;
        logic [31:0]     exp_data;
        logic            exp_to;
        int              exp_reads;
    } vec_t;

    vec_t  vt [4];
    string vn [4];

    initial begin
        int tb0;
        vn[0] = "cmd0";  vt[0] = '{6'd0,  32'h0,     1'b0, 3, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h01, 8'hFF, 8'hFF}, 8'h95, 8'h01, 32'h0, 1'b0, 3};
        vn[1] = "cmd8";  vt[1] = '{6'd8,  32'h1AA,   1'b1, 5, {8'h0, 8'h0, 8'h0, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h01}, 8'h87, 8'h01, 32'h1AA, 1'b0, 5};
        vn[2] = "cmd58"; vt[2] = '{6'd58, 32'h0,     1'b1, 0, 64'h0, crc_ref(6'd58, 32'h0), 8'hFF, 32'h0, 1'b1, NCR};
        vn[3] = "cmd17"; vt[3] = '{6'd17, 32'h200,   1'b0, 1, 64'h0, crc_ref(6'd17, 32'h200), 8'h00, 32'h0, 1'b0, 1};

        repeat (3) @(negedge clk);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst resp_valid", resp_valid, 0);
        check("rst write_en", spi_write_en, 0);
        check("rst read_en", spi_read_en, 0);
        check("rst data_write", spi_data_write, 8'hFF);
        check("rst resp_r1", resp_r1, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) resp_mem[i] = vt[v].rsp[i];
            resp_len = vt[v].nresp;
            run_cmd(vn[v], vt[v].idx, vt[v].arg, vt[v].lng, 1'b0, 0);
            check({vn[v], " tbl_crc"}, tx_log[(tx_cnt - 1) % 4096], vt[v].exp_crc);
            check({vn[v], " tbl_r1"}, resp_r1, vt[v].exp_r1);
            check({vn[v], " tbl_data"}, resp_data, vt[v].exp_data);
            check({vn[v], " tbl_to"}, resp_timeout, vt[v].exp_to);
            check({vn[v], " tbl_reads"}, rd_cnt - rd_base, vt[v].exp_reads);
        end

        // cmd_valid held through the command, engine busy stretched 20 cycles
        resp_mem[0] = 8'h05; resp_len = 1;
        tb0 = tx_cnt;
        run_cmd("hold", 6'd55, 32'h0, 1'b0, 1'b1, 20);
        repeat (20) @(negedge clk);
        check("hold one_frame", tx_cnt - tb0, FRAME);

        // Reset during the third TX byte
        resp_mem[0] = 8'hFF; resp_mem[1] = 8'hFF; resp_mem[2] = 8'h01; resp_len = 3;
        tb0 = tx_cnt;
        @(negedge clk);
        cmd_index = 6'd0; cmd_arg = 32'h0; resp_long = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 500 && (tx_cnt - tb0) < 3; c++) @(negedge clk);
        check("mid_rst reached_byte3", tx_cnt - tb0, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst ready_now", cmd_ready, 1);
        @(posedge clk); #1;
        check("mid_rst ready", cmd_ready, 1);
        check("mid_rst busy", busy, 0);
        check("mid_rst wr_en", spi_write_en, 0);
        check("mid_rst rd_en", spi_read_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("after_rst", 6'd0, 32'h0, 1'b0, 1'b0, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 24; n++) begin
            int lead;
            lead = $urandom_range(0, NCR + 1);
            for (int i = 0; i < lead; i++)
                resp_mem[i] = ($urandom_range(0, 3) == 0) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'hFF;
            resp_mem[lead] = 8'($urandom_range(0, 127));
            for (int i = 1; i <= 4; i++) resp_mem[lead + i] = 8'($urandom_range(0, 255));
            resp_len = lead + 5;
            wr_len = $urandom_range(1, 4);
            rd_len = $urandom_range(1, 4);
            run_cmd($sformatf("rnd%0d", n), 6'($urandom_range(0, 63)), $urandom,
                    1'($urandom_range(0, 1)), 1'b0, 0);
        end

        check("no_strobe_while_busy", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
